bk_sub_pipe: RTL and testbench

- Pipelined 12-bit unsigned/two's-complement subtractor D = X − Y, computed as X + ~Y + 1 on a Brent-Kung parallel-prefix carry network.
- Companion to the combinational 12-bit Brent-Kung adder: same prefix structure, opposite arithmetic direction.
- Registered across two stages with a valid/ready stream interface.
- Sits in datapaths that need a back-pressurable difference/compare unit (borrow, zero and signed-overflow flags).

---
 rtl/bk_arith_pkg.sv | 25 ++
 rtl/bk_gp_cell.sv | 14 +
 rtl/bk_sub_pipe.sv | 179 +++++++++++++++++
 tb/tb_bk_sub_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_arith_pkg.sv
// Shared arithmetic definitions for the Brent-Kung prefix datapaths.
package bk_arith_pkg;

    localparam int W_DEFAULT = 12;

    // One prefix node: group generate and group propagate.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix levels needed to span n bits.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// Brent-Kung prefix combine: (gi1,pi1) is the upper group, (gi2,pi2) the lower.
module bk_gp_cell (
    input  logic gi1,
    input  logic pi1,
    input  logic gi2,
    input  logic pi2,
    output logic go,
    output logic po
);

    assign go = gi1 | (gi2 & pi1);
    assign po = pi1 & pi2;

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage pipelined Brent-Kung subtractor, diff = x + ~y + 1, valid/ready stream.
module bk_sub_pipe
    import bk_arith_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero,
    output logic         ovf
);

    localparam int L = clog2(W);

    logic s1_valid;
    logic s2_adv;
    logic in_fire;
    logic s2_load;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = s2_adv && s1_valid;

    // Up-sweep: level 0 holds bitwise g/p of x and ~y; level lv combines
    // nodes whose index+1 is a multiple of 2^lv with the node 2^(lv-1) below.
    for (genvar lv = 0; lv <= L; lv++) begin : g_up
        gp_t n [W];
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (lv == 0) begin : g_leaf
                assign n[i].g = x[i] & ~y[i];
                assign n[i].p = x[i] ^ ~y[i];
            end else if (((i + 1) % (1 << lv)) == 0) begin : g_cell
                bk_gp_cell u_cell (
                    .gi1 (g_up[lv-1].n[i].g),
                    .pi1 (g_up[lv-1].n[i].p),
                    .gi2 (g_up[lv-1].n[i - (1 << (lv - 1))].g),
                    .pi2 (g_up[lv-1].n[i - (1 << (lv - 1))].p),
                    .go  (n[i].g),
                    .po  (n[i].p)
                );
            end else begin : g_pass
                assign n[i] = g_up[lv-1].n[i];
            end
        end
    end

    gp_t [W-1:0] up_d;
    logic [W-1:0] p0_d;

    for (genvar i = 0; i < W; i++) begin : g_s1_d
        assign up_d[i] = g_up[L].n[i];
        assign p0_d[i] = g_up[0].n[i].p;
    end

    gp_t [W-1:0] s1_up;
    logic [W-1:0] s1_p0;

    // Stage 1 valid: refill when the stage can accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 data: bitwise propagate and up-sweep prefix nodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_up <= '0;
            s1_p0 <= '0;
        end else if (in_fire) begin
            s1_up <= up_d;
            s1_p0 <= p0_d;
        end
    end

    // Down-sweep: level dl uses stride s = 2^(L-1-dl) and fills nodes
    // i = 3s-1 + 2s*m from the complete prefix at i-s.
    for (genvar dl = 0; dl < L; dl++) begin : g_dn
        localparam int S = (dl == 0) ? 1 : (1 << (L - 1 - dl));
        gp_t n [W];
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (dl == 0) begin : g_root
                assign n[i] = s1_up[i];
            end else if ((i >= 3 * S - 1) && (((i - (3 * S - 1)) % (2 * S)) == 0)) begin : g_cell
                bk_gp_cell u_cell (
                    .gi1 (g_dn[dl-1].n[i].g),
                    .pi1 (g_dn[dl-1].n[i].p),
                    .gi2 (g_dn[dl-1].n[i - S].g),
                    .pi2 (g_dn[dl-1].n[i - S].p),
                    .go  (n[i].g),
                    .po  (n[i].p)
                );
            end else begin : g_pass
                assign n[i] = g_dn[dl-1].n[i];
            end
        end
    end

    gp_t [W-1:0] pf;

    for (genvar i = 0; i < W; i++) begin : g_pf
        assign pf[i] = g_dn[L-1].n[i];
    end

    logic [W-1:0] c;
    logic [W-1:0] diff_d;
    logic         cout;

    // Carries with constant carry-in 1: c[i] = G[i-1:0] | P[i-1:0].
    always_comb begin
        c    = '0;
        c[0] = 1'b1;
        for (int unsigned i = 1; i < W; i++) begin
            c[i] = pf[i-1].g | pf[i-1].p;
        end
        cout   = pf[W-1].g | pf[W-1].p;
        diff_d = s1_p0 ^ c;
    end

    // Output stage valid: advances whenever the output is empty or drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
        end
    end

    // Output stage data: difference and borrow, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff   <= '0;
            borrow <= 1'b0;
        end else if (s2_load) begin
            diff   <= diff_d;
            borrow <= ~cout;
        end
    end

    if (FLAGS_EN) begin : g_flags
        logic s1_xs;

        // Minuend sign travels with stage 1 for the overflow flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_xs <= 1'b0;
            end else if (in_fire) begin
                s1_xs <= x[W-1];
            end
        end

        // Signs differ exactly when p0 of the top bit is 0 (x ^ ~y).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zero <= 1'b0;
                ovf  <= 1'b0;
            end else if (s2_load) begin
                zero <= (diff_d == '0);
                ovf  <= !s1_p0[W-1] && (diff_d[W-1] != s1_xs);
            end
        end
    end else begin : g_no_flags
        assign zero = 1'b0;
        assign ovf  = 1'b0;
    end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Directed and randomized checks for the pipelined Brent-Kung subtractor.
module tb_bk_sub_pipe;

    localparam int W = 12;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bk_sub_pipe #(.W(W), .FLAGS_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        total++;
        if ({diff, borrow, zero, ovf} !== '0) begin
            bad++; $display("FAIL reset outputs got diff=%h b=%b z=%b o=%b want all 0", diff, borrow, zero, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_release out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [W-1:0] vx [8] = '{12'hABC, 12'h000, 12'h000, 12'h800, 12'h7FF, 12'h5A5, 12'h3C7, 12'h010};
        logic [W-1:0] vy [8] = '{12'h123, 12'h001, 12'hFFF, 12'h001, 12'hFFF, 12'h5A5, 12'h000, 12'h00F};
        logic [W-1:0] vd [8] = '{12'h999, 12'hFFF, 12'h001, 12'h7FF, 12'h800, 12'h000, 12'h3C7, 12'h001};
        logic [7:0] vb = 8'b0001_0110;   // bit k = borrow of vector k
        logic [7:0] vz = 8'b0010_0000;
        logic [7:0] vo = 8'b0001_1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            x = vx[k];
            y = vy[k];
            in_valid = 1'b1;
            out_ready = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL basic[%0d] in_ready got %b want 1", k, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL basic[%0d] early out_valid got %b want 0", k, out_valid); end
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL basic[%0d] latency out_valid got %b want 1", k, out_valid); end
            total++;
            if (diff !== vd[k]) begin bad++; $display("FAIL basic[%0d] diff got %h want %h", k, diff, vd[k]); end
            total++;
            if (borrow !== vb[k]) begin bad++; $display("FAIL basic[%0d] borrow got %b want %b", k, borrow, vb[k]); end
            total++;
            if (zero !== vz[k]) begin bad++; $display("FAIL basic[%0d] zero got %b want %b", k, zero, vz[k]); end
            total++;
            if (ovf !== vo[k]) begin bad++; $display("FAIL basic[%0d] ovf got %b want %b", k, ovf, vo[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] px [4] = '{12'h100, 12'h200, 12'h300, 12'h400};
        logic [W-1:0] py [4] = '{12'h001, 12'h002, 12'h003, 12'h004};
        logic [W-1:0] pd [4] = '{12'h0FF, 12'h1FE, 12'h2FD, 12'h3FC};
        logic [9:0] ordy = 10'b11_1110_0011;   // bit c = out_ready in cycle c
        logic [9:0] erdy = 10'b11_1110_0011;
        logic [9:0] eval = 10'b01_1111_1100;
        int sent = 0;
        int rcv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (sent < 4);
            x = (sent < 4) ? px[sent] : '0;
            y = (sent < 4) ? py[sent] : '0;
            out_ready = ordy[c];
            #1;
            total++;
            if (in_ready !== erdy[c]) begin bad++; $display("FAIL bp_in_ready[c%0d] got %b want %b", c, in_ready, erdy[c]); end
            total++;
            if (out_valid !== eval[c]) begin bad++; $display("FAIL bp_out_valid[c%0d] got %b want %b", c, out_valid, eval[c]); end
            if (out_valid && !out_ready) begin
                total++;
                if (diff !== 12'h0FF) begin bad++; $display("FAIL bp_hold[c%0d] diff got %h want 0ff", c, diff); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (rcv >= 4) begin
                    bad++; $display("FAIL bp_extra[c%0d] got diff %h want no result", c, diff);
                end else if (diff !== pd[rcv]) begin
                    bad++; $display("FAIL bp_order[%0d] diff got %h want %h", rcv, diff, pd[rcv]);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        total++;
        if (rcv != 4) begin bad++; $display("FAIL bp_count got %0d results want 4", rcv); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        x = 12'h111;
        y = 12'h011;
        @(negedge clk);
        x = 12'h222;
        y = 12'h022;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid inflight out_valid got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid out_valid got %b want 0", out_valid); end
        total++;
        if ({diff, borrow, zero, ovf} !== '0) begin
            bad++; $display("FAIL rst_mid outputs got diff=%h b=%b z=%b o=%b want all 0", diff, borrow, zero, ovf);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid stale out_valid got %b want 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b1;
        x = 12'h010;
        y = 12'h00F;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid post in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid post early out_valid got %b want 0", out_valid); end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || diff !== 12'h001 || borrow !== 1'b0) begin
            bad++; $display("FAIL rst_mid post result got v=%b diff=%h b=%b want v=1 diff=001 b=0", out_valid, diff, borrow);
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid no_stale out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t got;
        logic         prev_hold = 1'b0;
        logic [W-1:0] prev_diff = '0;
        logic [W-1:0] d;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            x = W'($urandom);
            y = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_hold) begin
                total++;
                if (out_valid !== 1'b1 || diff !== prev_diff) begin
                    bad++; $display("FAIL rnd_hold[%0d] got v=%b diff=%h want v=1 diff=%h", n, out_valid, diff, prev_diff);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                got = '{d: diff, b: borrow, z: zero, o: ovf};
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_unexpected[%0d] got %h want no result", n, got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        bad++; $display("FAIL rnd_result[%0d] got d=%h b=%b z=%b o=%b want d=%h b=%b z=%b o=%b",
                                        n, got.d, got.b, got.z, got.o, e.d, e.b, e.z, e.o);
                    end
                end
            end
            if (in_valid && in_ready) begin
                d = x - y;
                e.d = d;
                e.b = (x < y);
                e.z = (d == '0);
                e.o = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
                q.push_back(e);
            end
            prev_hold = out_valid && !out_ready;
            prev_diff = diff;
        end
        for (int n = 0; n < 10 && q.size() > 0; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                total++;
                e = q.pop_front();
                if (diff !== e.d || borrow !== e.b) begin
                    bad++; $display("FAIL rnd_drain got d=%h b=%b want d=%h b=%b", diff, borrow, e.d, e.b);
                end
            end
        end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got %0d pending want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
